// File: rtl/cnt_pkg.sv
// Shared constants for the multi-channel counter slice.
// Overflow policy selectors used by count_chan and multi_count_sum.
package cnt_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

endpackage

// File: rtl/count_chan.sv
// Single counter channel: clr > load > en priority,
// wrap or saturate on overflow, one-cycle ovf pulse.
module count_chan
  import cnt_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MODE  = MODE_WRAP
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] cnt,
  output logic             ovf
);

  logic [WIDTH:0] sum;
  logic           carry;

  assign sum   = {1'b0, cnt} + {1'b0, step};
  assign carry = sum[WIDTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      ovf <= 1'b0;
      priority case (1'b1)
        clr:  cnt <= '0;
        load: cnt <= load_val;
        en: begin
          ovf <= carry;
          if (MODE == MODE_SAT && carry)
            cnt <= '1;
          else
            cnt <= sum[WIDTH-1:0];
        end
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/multi_count_sum.sv
// Bank of CHANNELS counters with a registered full-width sum.
// q lags cnt by one edge; q_valid marks the first edge out of reset.
module multi_count_sum
  import cnt_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2,
  parameter int MODE     = MODE_WRAP,
  localparam int SUMW    = WIDTH + $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clr,
  input  logic [CHANNELS-1:0]       load,
  input  logic [WIDTH-1:0]          load_val,
  input  logic [CHANNELS-1:0]       en,
  input  logic [WIDTH-1:0]          step,
  output logic [CHANNELS*WIDTH-1:0] cnt,
  output logic [SUMW-1:0]           q,
  output logic                      q_valid,
  output logic [CHANNELS-1:0]       ovf
);

  logic [SUMW-1:0] sum;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    count_chan #(
      .WIDTH (WIDTH),
      .MODE  (MODE)
    ) u_chan (
      .clk      (clk),
      .reset_n  (reset_n),
      .clr      (clr),
      .load     (load[i]),
      .load_val (load_val),
      .en       (en[i]),
      .step     (step),
      .cnt      (cnt[i*WIDTH +: WIDTH]),
      .ovf      (ovf[i])
    );
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < CHANNELS; i++)
      sum = sum + SUMW'(cnt[i*WIDTH +: WIDTH]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else begin
      q       <= sum;
      q_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multi_count_sum.sv
// Bench for multi_count_sum: three configurations against
// an arithmetic model, directed scenarios, then random traffic.
module tb_multi_count_sum;
  import cnt_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clr;
  logic [1:0]  ld_ab, en_ab;
  logic [7:0]  lv_ab, st_ab;
  logic [2:0]  ld_c, en_c;
  logic [3:0]  lv_c, st_c;
  logic [15:0] cnt_a, cnt_b;
  logic [11:0] cnt_c;
  logic [8:0]  q_a, q_b;
  logic [5:0]  q_c;
  logic        qv_a, qv_b, qv_c;
  logic [1:0]  ovf_a, ovf_b;
  logic [2:0]  ovf_c;

  int total = 0;
  int bad = 0;
  bit chk = 0;

  int ma[2], mb[2], mc[3];
  bit oa[2], ob[2], oc[3];
  int qa, qb, qc;
  bit mqv;

  always #5 clk = ~clk;

  multi_count_sum #(.WIDTH(8), .CHANNELS(2), .MODE(MODE_WRAP)) ua (
    .clk(clk), .reset_n(reset_n), .clr(clr),
    .load(ld_ab), .load_val(lv_ab), .en(en_ab), .step(st_ab),
    .cnt(cnt_a), .q(q_a), .q_valid(qv_a), .ovf(ovf_a)
  );

  multi_count_sum #(.WIDTH(8), .CHANNELS(2), .MODE(MODE_SAT)) ub (
    .clk(clk), .reset_n(reset_n), .clr(clr),
    .load(ld_ab), .load_val(lv_ab), .en(en_ab), .step(st_ab),
    .cnt(cnt_b), .q(q_b), .q_valid(qv_b), .ovf(ovf_b)
  );

  multi_count_sum #(.WIDTH(4), .CHANNELS(3), .MODE(MODE_WRAP)) uc (
    .clk(clk), .reset_n(reset_n), .clr(clr),
    .load(ld_c), .load_val(lv_c), .en(en_c), .step(st_c),
    .cnt(cnt_c), .q(q_c), .q_valid(qv_c), .ovf(ovf_c)
  );

  task automatic ce(input string nm, input logic [31:0] got,
                    input int exp);
    total++;
    if (got !== 32'(exp)) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  function automatic int nxt(int c, bit cl, bit ld, bit en,
                             int lv, int st, int max, bit sat);
    int s;
    if (cl) return 0;
    if (ld) return lv;
    if (!en) return c;
    s = c + st;
    if (s < max) return s;
    return sat ? max - 1 : s - max;
  endfunction

  function automatic bit ovn(int c, bit cl, bit ld, bit en,
                             int st, int max);
    return !cl && !ld && en && (c + st >= max);
  endfunction

  // Reference: q takes the pre-edge counts, then counts advance
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      foreach (ma[i]) begin ma[i] = 0; oa[i] = 0; end
      foreach (mb[i]) begin mb[i] = 0; ob[i] = 0; end
      foreach (mc[i]) begin mc[i] = 0; oc[i] = 0; end
      qa = 0; qb = 0; qc = 0; mqv = 0;
    end else begin
      qa = ma[0] + ma[1];
      qb = mb[0] + mb[1];
      qc = mc[0] + mc[1] + mc[2];
      for (int i = 0; i < 2; i++) begin
        oa[i] = ovn(ma[i], clr, ld_ab[i], en_ab[i], int'(st_ab), 256);
        ma[i] = nxt(ma[i], clr, ld_ab[i], en_ab[i],
                    int'(lv_ab), int'(st_ab), 256, 1'b0);
        ob[i] = ovn(mb[i], clr, ld_ab[i], en_ab[i], int'(st_ab), 256);
        mb[i] = nxt(mb[i], clr, ld_ab[i], en_ab[i],
                    int'(lv_ab), int'(st_ab), 256, 1'b1);
      end
      for (int i = 0; i < 3; i++) begin
        oc[i] = ovn(mc[i], clr, ld_c[i], en_c[i], int'(st_c), 16);
        mc[i] = nxt(mc[i], clr, ld_c[i], en_c[i],
                    int'(lv_c), int'(st_c), 16, 1'b0);
      end
      mqv = 1;
    end
  end

  always @(negedge clk) begin
    if (chk) begin
      for (int i = 0; i < 2; i++) begin
        ce("cnt_a", 32'(cnt_a[i*8 +: 8]), ma[i]);
        ce("ovf_a", 32'(ovf_a[i]), int'(oa[i]));
        ce("cnt_b", 32'(cnt_b[i*8 +: 8]), mb[i]);
        ce("ovf_b", 32'(ovf_b[i]), int'(ob[i]));
      end
      for (int i = 0; i < 3; i++) begin
        ce("cnt_c", 32'(cnt_c[i*4 +: 4]), mc[i]);
        ce("ovf_c", 32'(ovf_c[i]), int'(oc[i]));
      end
      ce("q_a", 32'(q_a), qa);
      ce("q_b", 32'(q_b), qb);
      ce("q_c", 32'(q_c), qc);
      ce("qv_a", 32'(qv_a), int'(mqv));
      ce("qv_b", 32'(qv_b), int'(mqv));
      ce("qv_c", 32'(qv_c), int'(mqv));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    clr = 0;
    ld_ab = 0; en_ab = 0; lv_ab = 0; st_ab = 0;
    ld_c = 0; en_c = 0; lv_c = 0; st_c = 0;
    tick();
    tick();
    ce("rst cnt_a", 32'(cnt_a), 0);
    ce("rst q_a", 32'(q_a), 0);
    ce("rst qv_a", 32'(qv_a), 0);
    ce("rst ovf_a", 32'(ovf_a), 0);
    chk = 1;

    // free run
    @(negedge clk);
    reset_n = 1'b1;
    en_ab = 2'b11;
    st_ab = 8'd1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      ce("free cnt0", 32'(cnt_a[7:0]), k);
      ce("free cnt1", 32'(cnt_a[15:8]), k);
      ce("free q", 32'(q_a), 2 * (k - 1));
      ce("free qv", 32'(qv_a), 1);
    end

    // wrap
    en_ab = 0; clr = 1;
    tick();
    clr = 0; ld_ab = 2'b01; lv_ab = 8'd255;
    tick();
    ce("wrap load", 32'(cnt_a[7:0]), 255);
    ld_ab = 0; en_ab = 2'b01; st_ab = 8'd1;
    tick();
    ce("wrap cnt0", 32'(cnt_a[7:0]), 0);
    ce("wrap ovf", 32'(ovf_a), 1);
    ce("wrap q", 32'(q_a), 255);
    ce("sat hold", 32'(cnt_b[7:0]), 255);
    ce("sat hold ovf", 32'(ovf_b), 1);
    en_ab = 0;
    tick();
    ce("wrap ovf end", 32'(ovf_a), 0);
    ce("wrap q next", 32'(q_a), 0);

    // saturate
    ld_ab = 2'b11; lv_ab = 8'd250;
    tick();
    ld_ab = 0; en_ab = 2'b01; st_ab = 8'd10;
    tick();
    ce("sat cnt0", 32'(cnt_b[7:0]), 255);
    ce("sat ovf", 32'(ovf_b), 1);
    ce("wrap260", 32'(cnt_a[7:0]), 4);
    tick();
    ce("sat cnt0 again", 32'(cnt_b[7:0]), 255);
    ce("sat ovf again", 32'(ovf_b), 1);
    en_ab = 0; ld_ab = 2'b10; lv_ab = 8'd255;
    tick();
    ce("sat ovf clr", 32'(ovf_b), 0);
    ld_ab = 0;
    tick();
    ce("sat q510", 32'(q_b), 510);

    // priority
    clr = 1; ld_ab = 2'b11; en_ab = 2'b11; lv_ab = 8'd77;
    ld_c = 3'b111; en_c = 3'b111; lv_c = 4'd9; st_c = 4'd1;
    tick();
    ce("prio clr", 32'(cnt_a), 0);
    ce("prio clr c", 32'(cnt_c), 0);
    clr = 0;
    tick();
    ce("prio load", 32'(cnt_a), 32'h4D4D);
    ce("prio ovf", 32'(ovf_a), 0);

    // width
    ld_ab = 0; en_ab = 0;
    en_c = 0; lv_c = 4'd15;
    tick();
    ld_c = 0;
    tick();
    ce("w4 q45", 32'(q_c), 45);

    // async reset mid-count
    en_ab = 2'b11; st_ab = 8'd3; en_c = 3'b111; st_c = 4'd1;
    repeat (3) tick();
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    ce("arst cnt_a", 32'(cnt_a), 0);
    ce("arst q_a", 32'(q_a), 0);
    ce("arst qv_a", 32'(qv_a), 0);
    ce("arst ovf_a", 32'(ovf_a), 0);
    ce("arst cnt_c", 32'(cnt_c), 0);
    ce("arst q_c", 32'(q_c), 0);
    tick();
    reset_n = 1'b1;
    tick();
    ce("rel qv", 32'(qv_a), 1);
    ce("rel cnt0", 32'(cnt_a[7:0]), 3);
    ce("rel q", 32'(q_a), 0);

    // random traffic
    repeat (600) begin
      clr   = ($urandom_range(0, 24) == 0);
      ld_ab = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
      en_ab = 2'($urandom);
      lv_ab = 8'($urandom);
      st_ab = ($urandom_range(0, 5) == 0) ? 8'd0 :
              ($urandom_range(0, 1) == 0) ? 8'($urandom_range(1, 8)) :
              8'($urandom);
      ld_c  = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000;
      en_c  = 3'($urandom);
      lv_c  = 4'($urandom);
      st_c  = 4'($urandom);
      tick();
    end

    @(negedge clk);
    #1 chk = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
